// File: rtl/uart_pkg.sv
// Shared UART constants and the clog2 constant function.
// Used for parameter defaults and counter sizing across the UART blocks.
package uart_pkg;
    localparam int DIV_W        = 16;
    localparam int FRAC_W       = 4;
    localparam int OSR          = 16;
    localparam int DEF_DIV_INT  = 27;
    localparam int DEF_DIV_FRAC = 2;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/frac_period_ctr.sv
// Fractional period engine: down-counter plus phase accumulator, flags each period end.
// period_end is combinational from cnt; no backpressure, free-running while en is high.
module frac_period_ctr #(
    parameter int DIV_W       = uart_pkg::DIV_W,
    parameter int FRAC_W      = uart_pkg::FRAC_W,
    parameter int DEF_DIV_INT = uart_pkg::DEF_DIV_INT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_nxt,
    input  logic [FRAC_W-1:0] frac_act,
    input  logic              restart,
    output logic              period_end
);
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;
    logic              carry;

    assign period_end = en && (cnt == '0);
    assign sum        = {1'b0, acc} + {1'b0, frac_act};
    // A divisor changeover starts a clean period: no stale carry leaks into it.
    assign carry      = sum[FRAC_W] & ~restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= DIV_W'(DEF_DIV_INT - 1);
            acc <= '0;
        end else if (!en) begin
            cnt <= div_nxt - DIV_W'(1);
            acc <= '0;
        end else if (period_end) begin
            cnt <= div_nxt - DIV_W'(1) + DIV_W'(carry);
            acc <= restart ? '0 : sum[FRAC_W-1:0];
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end
endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample, bit and mid-bit ticks with glitch-free divisor reload.
// Ticks are registered, 1 clk after each period end; no backpressure, ticks are fire-and-forget.
module baud_gen_frac #(
    parameter int DIV_W        = uart_pkg::DIV_W,
    parameter int FRAC_W       = uart_pkg::FRAC_W,
    parameter int OSR          = uart_pkg::OSR,
    parameter int DEF_DIV_INT  = uart_pkg::DEF_DIV_INT,
    parameter int DEF_DIV_FRAC = uart_pkg::DEF_DIV_FRAC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_pending,
    output logic              tick_os,
    output logic              tick_bit,
    output logic              tick_mid
);
    import uart_pkg::*;

    localparam int OS_W    = (OSR > 1) ? clog2(OSR) : 1;
    localparam int MID_IDX = (OSR > 1) ? OSR / 2 - 1 : 0;

    logic [DIV_W-1:0]  act_int, sh_int, nxt_int, ld_int;
    logic [FRAC_W-1:0] act_frac, sh_frac, nxt_frac;
    logic [OS_W-1:0]   os_cnt;
    logic              pend, period_end, apply;

    assign ld_int      = (div_int == '0) ? DIV_W'(1) : div_int;
    assign apply       = pend & period_end;
    assign div_pending = pend;

    // While stopped, loads take effect immediately since there is no period to protect.
    always_comb begin
        nxt_int  = act_int;
        nxt_frac = act_frac;
        if (!en) begin
            if (div_load) begin
                nxt_int  = ld_int;
                nxt_frac = div_frac;
            end else if (pend) begin
                nxt_int  = sh_int;
                nxt_frac = sh_frac;
            end
        end else if (apply) begin
            nxt_int  = sh_int;
            nxt_frac = sh_frac;
        end
    end

    frac_period_ctr #(
        .DIV_W       (DIV_W),
        .FRAC_W      (FRAC_W),
        .DEF_DIV_INT (DEF_DIV_INT)
    ) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_nxt    (nxt_int),
        .frac_act   (act_frac),
        .restart    (apply),
        .period_end (period_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_int  <= DIV_W'(DEF_DIV_INT);
            act_frac <= FRAC_W'(DEF_DIV_FRAC);
            sh_int   <= DIV_W'(DEF_DIV_INT);
            sh_frac  <= FRAC_W'(DEF_DIV_FRAC);
            pend     <= 1'b0;
            os_cnt   <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            tick_mid <= 1'b0;
        end else begin
            act_int  <= nxt_int;
            act_frac <= nxt_frac;

            if (!en) begin
                pend <= 1'b0;
            end else if (div_load) begin
                sh_int  <= ld_int;
                sh_frac <= div_frac;
                pend    <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end

            if (!en)
                os_cnt <= '0;
            else if (period_end)
                os_cnt <= (os_cnt == OS_W'(OSR - 1)) ? '0 : os_cnt + OS_W'(1);

            tick_os  <= period_end;
            tick_bit <= period_end && (os_cnt == OS_W'(OSR - 1));
            tick_mid <= period_end && (os_cnt == OS_W'(MID_IDX));
        end
    end
endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: tick times come from the closed-form
// period schedule T_k = start + div-1 + k*div + floor(k*frac/2^FRAC_W).
module tb_baud_gen_frac;
    import uart_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              div_load = 1'b0;
    logic [DIV_W-1:0]  div_int = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              div_pending, tick_os, tick_bit, tick_mid;

    logic rst1_n = 1'b0, en1 = 1'b0, ld1 = 1'b0, run1 = 1'b0;
    logic pend1, os1, bit1, mid1;

    always #5 clk = ~clk;

    baud_gen_frac dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div_int(div_int), .div_frac(div_frac),
        .div_load(div_load), .div_pending(div_pending), .tick_os(tick_os),
        .tick_bit(tick_bit), .tick_mid(tick_mid)
    );

    baud_gen_frac #(.OSR(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .en(en1), .div_int(DIV_W'(27)), .div_frac(FRAC_W'(0)),
        .div_load(ld1), .div_pending(pend1), .tick_os(os1),
        .tick_bit(bit1), .tick_mid(mid1)
    );

    typedef struct {
        int cyc;
        bit os;
        bit bt;
        bit md;
        bit pd;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;
    int   mcnt = 0;
    bit   done = 0;

    // Reference model state: active/shadow divisor, segment start and period index.
    int m_div, m_frac, s_div, s_frac, seg, k, m_os;
    bit m_pend, m_run, m_last_end;

    task automatic model_reset();
        m_div  = DEF_DIV_INT;
        m_frac = DEF_DIV_FRAC;
        m_pend = 0;
        m_run  = 0;
        m_os   = 0;
        m_last_end = 0;
    endtask

    task automatic model_edge(input bit e, input bit ld, input int li, input int lf);
        rec_t r;
        int   nd;
        nd = (li == 0) ? 1 : li;
        r.cyc = ecnt; r.os = 0; r.bt = 0; r.md = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!e) begin
            if (ld) begin
                m_div = nd; m_frac = lf;
            end else if (m_pend) begin
                m_div = s_div; m_frac = s_frac;
            end
            m_pend = 0; m_run = 0; m_os = 0;
        end else begin
            if (!m_run) begin
                m_run = 1; seg = ecnt; k = 0;
            end
            if (ecnt == seg + m_div - 1 + k * m_div + ((k * m_frac) >> FRAC_W)) begin
                r.os = 1;
                r.bt = (m_os == OSR - 1);
                r.md = (m_os == OSR / 2 - 1);
                m_os = (m_os + 1) % OSR;
                if (m_pend) begin
                    m_div = s_div; m_frac = s_frac; m_pend = 0;
                    seg = ecnt + 1; k = 0;
                end else begin
                    k++;
                end
            end
            if (ld) begin
                s_div = nd; s_frac = lf; m_pend = 1;
            end
        end
        m_last_end = r.os;
        r.pd = m_pend;
        q.push_back(r);
    endtask

    task automatic step(input bit e, input bit ld, input int li, input int lf);
        en = e; div_load = ld; div_int = DIV_W'(li); div_frac = FRAC_W'(lf);
        @(posedge clk);
        ecnt++;
        model_edge(e, ld, li, lf);
        #1;
    endtask

    // Async reset clears outputs at once, so the record for the last edge becomes all-zero.
    task automatic do_reset();
        rec_t r;
        rst_n = 1'b0;
        model_reset();
        r = q.pop_back();
        r.os = 0; r.bt = 0; r.md = 0; r.pd = 0;
        q.push_back(r);
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached within cycle budget at cycle %0d", name, ecnt);
    endtask

    always @(posedge clk) mcnt++;

    always @(negedge clk) begin
        rec_t r;
        if (!done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at cycle %0d", mcnt);
            end else begin
                r = q.pop_front();
                if (r.cyc != mcnt || tick_os !== r.os || tick_bit !== r.bt ||
                    tick_mid !== r.md || div_pending !== r.pd) begin
                    errors++;
                    $display("FAIL ticks cyc=%0d tag=%0d got os=%b bit=%b mid=%b pend=%b want os=%b bit=%b mid=%b pend=%b",
                             mcnt, r.cyc, tick_os, tick_bit, tick_mid, div_pending,
                             r.os, r.bt, r.md, r.pd);
                end
            end
        end
    end

    // OSR=1 instance: tick_bit and tick_mid mirror tick_os, period fixed at 27.
    int since1 = -1;
    int n1 = 0;
    always @(negedge clk) begin
        if (run1 && !done) begin
            checks++;
            if (bit1 !== os1 || mid1 !== os1) begin
                errors++;
                $display("FAIL osr1_align cyc=%0d got os=%b bit=%b mid=%b want all equal",
                         mcnt, os1, bit1, mid1);
            end
            if (since1 >= 0) since1++;
            if (os1 === 1'b1) begin
                n1++;
                if (since1 >= 0) begin
                    checks++;
                    if (since1 != 27) begin
                        errors++;
                        $display("FAIL osr1_period cyc=%0d got %0d want 27", mcnt, since1);
                    end
                end
                since1 = 0;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst1_n = 1'b1;
        ld1 = 1'b1;
        @(posedge clk);
        #1 ld1 = 1'b0;
        en1  = 1'b1;
        run1 = 1'b1;
    end

    initial begin
        int li, lf, hold;
        bit e;
        model_reset();
        repeat (3) step(0, 0, 0, 0);
        rst_n = 1'b1;

        // Default 27 + 2/16 divisor across several bit periods.
        repeat (1400) step(1, 0, 0, 0);

        // Mid-period load of 10/0 with the generator running.
        for (int i = 0; i < 100 && !m_last_end; i++) step(1, 0, 0, 0);
        if (!m_last_end) timeout("wait_period_end_t3");
        repeat (5) step(1, 0, 0, 0);
        step(1, 1, 10, 0);
        repeat (60) step(1, 0, 0, 0);

        // Random enables, loads and divisors.
        for (int i = 0; i < 40; i++) begin
            e  = ($urandom_range(0, 4) != 0);
            li = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            lf = int'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 40));
            step(e, ($urandom_range(0, 9) < 7), li, lf);
            repeat (hold) step(e, 0, 0, 0);
        end

        // Divisor 0 loaded while stopped behaves as 1.
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (64) step(1, 0, 0, 0);

        // Drop enable at os_cnt 5 for 7 cycles.
        step(0, 1, 6, 5);
        for (int i = 0; i < 200 && m_os != 5; i++) step(1, 0, 0, 0);
        if (m_os != 5) timeout("wait_os5");
        repeat (7) step(0, 0, 0, 0);
        repeat (150) step(1, 0, 0, 0);

        // Reset while a load is pending.
        for (int i = 0; i < 100 && !m_last_end; i++) step(1, 0, 0, 0);
        if (!m_last_end) timeout("wait_period_end_t6");
        step(1, 1, 9, 3);
        step(1, 0, 0, 0);
        do_reset();
        repeat (3) step(1, 0, 0, 0);
        rst_n = 1'b1;
        repeat (200) step(1, 0, 0, 0);

        @(negedge clk);
        #1 done = 1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", q.size());
        end
        checks++;
        if (n1 < 20) begin
            errors++;
            $display("FAIL osr1_tick_count got %0d want at least 20", n1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
